// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states, oversampling constants, parity helper.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  // Tick counter spans one bit more than a data bit so 24/32-tick stop bits still fit.
  localparam int TICK_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic parity_mismatch(input logic acc, input logic par_bit, input logic odd);
    return (acc ^ par_bit) != odd;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; resets to the idle-high line level.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic ff1_r;
  logic ff2_r;

  // Metastability filter chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff1_r <= 1'b1;
      ff2_r <= 1'b1;
    end else begin
      ff1_r <= d;
      ff2_r <= ff1_r;
    end
  end

  assign q = ff2_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, configurable data bits, optional parity and stop length.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TCK     = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tck,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done_tck,
  output logic       frame_err,
  output logic       parity_err
);

  localparam logic [TICK_W-1:0] S_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] S_BIT  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] S_STOP = TICK_W'(SB_TCK - 1);
  localparam logic [2:0]        N_LAST = 3'(DBIT - 1);
  localparam logic              PAR_EN  = (PARITY_EN != 0);
  localparam logic              PAR_ODD = (PARITY_ODD != 0);
  localparam int                SHIFT   = 8 - DBIT;

  logic              rxs_s;
  uart_state_e       state_r, state_nx_s;
  logic [TICK_W-1:0] s_r, s_nx_s;
  logic [2:0]        n_r, n_nx_s;
  logic [7:0]        b_r, b_nx_s;
  logic              p_r, p_nx_s;
  logic              mis_r, mis_nx_s;
  logic              brk_hold_r, brk_hold_nx_s;
  logic [7:0]        dout_r, dout_nx_s;
  logic              done_r, done_nx_s;
  logic              ferr_r, ferr_nx_s;
  logic              perr_r, perr_nx_s;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rxs_s)
  );

  // State, counters, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      s_r        <= '0;
      n_r        <= 3'd0;
      b_r        <= 8'd0;
      p_r        <= 1'b0;
      mis_r      <= 1'b0;
      brk_hold_r <= 1'b0;
      dout_r     <= 8'd0;
      done_r     <= 1'b0;
      ferr_r     <= 1'b0;
      perr_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      s_r        <= s_nx_s;
      n_r        <= n_nx_s;
      b_r        <= b_nx_s;
      p_r        <= p_nx_s;
      mis_r      <= mis_nx_s;
      brk_hold_r <= brk_hold_nx_s;
      dout_r     <= dout_nx_s;
      done_r     <= done_nx_s;
      ferr_r     <= ferr_nx_s;
      perr_r     <= perr_nx_s;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nx_s    = state_r;
    s_nx_s        = s_r;
    n_nx_s        = n_r;
    b_nx_s        = b_r;
    p_nx_s        = p_r;
    mis_nx_s      = mis_r;
    brk_hold_nx_s = brk_hold_r;
    dout_nx_s     = dout_r;
    done_nx_s     = 1'b0;
    ferr_nx_s     = ferr_r;
    perr_nx_s     = perr_r;

    case (state_r)
      ST_IDLE: begin
        // After a low stop bit the line must go high before a new start edge counts.
        if (brk_hold_r) begin
          brk_hold_nx_s = ~rxs_s;
        end else if (!rxs_s) begin
          state_nx_s = ST_START;
          s_nx_s     = '0;
          p_nx_s     = 1'b0;
          mis_nx_s   = 1'b0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end

      ST_START: begin
        if (s_tck) begin
          if (s_r == S_MID) begin
            if (!rxs_s) begin
              state_nx_s = ST_DATA;
              s_nx_s     = '0;
              n_nx_s     = 3'd0;
            end else begin
              state_nx_s = ST_IDLE;
            end
          end else begin
            s_nx_s = s_r + TICK_W'(1);
          end
        end else begin
          s_nx_s = s_r;
        end
      end

      ST_DATA: begin
        if (s_tck) begin
          if (s_r == S_BIT) begin
            b_nx_s = {rxs_s, b_r[7:1]};
            p_nx_s = p_r ^ rxs_s;
            s_nx_s = '0;
            if (n_r == N_LAST) begin
              state_nx_s = PAR_EN ? ST_PARITY : ST_STOP;
            end else begin
              n_nx_s = n_r + 3'd1;
            end
          end else begin
            s_nx_s = s_r + TICK_W'(1);
          end
        end else begin
          s_nx_s = s_r;
        end
      end

      ST_PARITY: begin
        if (s_tck) begin
          if (s_r == S_BIT) begin
            mis_nx_s   = parity_mismatch(p_r, rxs_s, PAR_ODD);
            s_nx_s     = '0;
            state_nx_s = ST_STOP;
          end else begin
            s_nx_s = s_r + TICK_W'(1);
          end
        end else begin
          s_nx_s = s_r;
        end
      end

      ST_STOP: begin
        if (s_tck) begin
          if (s_r == S_STOP) begin
            dout_nx_s     = b_r >> SHIFT;
            ferr_nx_s     = ~rxs_s;
            perr_nx_s     = mis_r;
            done_nx_s     = 1'b1;
            brk_hold_nx_s = ~rxs_s;
            s_nx_s        = '0;
            state_nx_s    = ST_IDLE;
          end else begin
            s_nx_s = s_r + TICK_W'(1);
          end
        end else begin
          s_nx_s = s_r;
        end
      end

      default: begin
        state_nx_s = ST_IDLE;
        s_nx_s     = '0;
      end
    endcase
  end

  assign dout        = dout_r;
  assign rx_done_tck = done_r;
  assign frame_err   = ferr_r;
  assign parity_err  = perr_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: no-parity and even-parity instances, frames checked against a bit-level model.
module tb_uart_rx;

  localparam int BIT_CLK = 256;

  logic clk = 1'b0;
  logic reset, s_tck, rx, rx_p;
  logic [7:0] dout, dout_p;
  logic done, done_p, ferr, ferr_p, perr, perr_p;

  int checks = 0;
  int errors = 0;
  logic [9:0] obs0[$], obs1[$], exp0[$], exp1[$];
  logic [9:0] got, want;
  logic [7:0] last0;

  always #5 clk = ~clk;

  uart_rx #(.DBIT(8), .SB_TCK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .s_tck(s_tck), .rx(rx),
    .dout(dout), .rx_done_tck(done), .frame_err(ferr), .parity_err(perr));

  uart_rx #(.DBIT(8), .SB_TCK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .reset(reset), .s_tck(s_tck), .rx(rx_p),
    .dout(dout_p), .rx_done_tck(done_p), .frame_err(ferr_p), .parity_err(perr_p));

  initial begin
    s_tck = 1'b0;
    forever begin
      repeat (15) @(negedge clk);
      s_tck = 1'b1;
      @(negedge clk);
      s_tck = 1'b0;
    end
  end

  // Capture each completed frame; a pulse longer than one clk shows up as an extra entry.
  always @(negedge clk) begin
    if (done === 1'b1) obs0.push_back({dout, ferr, perr});
    if (done_p === 1'b1) obs1.push_back({dout_p, ferr_p, perr_p});
  end

  // Reference: what a receiver must report for a frame, from the bits put on the line.
  function automatic logic [9:0] model(input logic [7:0] data, input int nd, input bit pen,
                                       input bit odd, input logic pbit, input logic stop);
    logic [7:0] d;
    int ones;
    logic pe;
    d = 8'd0;
    ones = 0;
    for (int i = 0; i < nd; i++) begin
      d[i] = data[i];
      ones += int'(data[i]);
    end
    if (pen) ones += int'(pbit);
    pe = pen && ((ones % 2) != (odd ? 1 : 0));
    return {d, ~stop, pe};
  endfunction

  task automatic drive_bit(input int line, input logic v);
    if (line == 0) rx = v; else rx_p = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input int line, input logic [7:0] data, input logic pbit,
                            input logic stop, input bit early);
    drive_bit(line, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(line, data[i]);
    if (line != 0) drive_bit(line, pbit);
    if (line == 0) exp0.push_back(model(data, 8, 1'b0, 1'b0, pbit, stop));
    else exp1.push_back(model(data, 8, 1'b1, 1'b0, pbit, stop));
    if (early) begin
      if (line == 0) rx = stop; else rx_p = stop;
      for (int t = 0; t < 2 * BIT_CLK; t++) begin
        @(negedge clk);
        if ((line == 0 ? done : done_p) === 1'b1) break;
      end
      checks++;
      if ((line == 0 ? done : done_p) !== 1'b1) begin
        errors++;
        $display("FAIL done_timeout: got no rx_done_tck within %0d clk, required a pulse", 2 * BIT_CLK);
      end
    end else begin
      drive_bit(line, stop);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({dout, done, ferr, perr} !== 11'd0) begin
      errors++; $display("FAIL reset_hold: got %h required 000", {dout, done, ferr, perr});
    end
    checks++;
    if ({dout_p, done_p, ferr_p, perr_p} !== 11'd0) begin
      errors++; $display("FAIL reset_hold_p: got %h required 000", {dout_p, done_p, ferr_p, perr_p});
    end
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if ({dout, done, ferr, perr, dout_p, done_p, ferr_p, perr_p} !== 22'd0) begin
      errors++; $display("FAIL reset_release: got %h required 0", {dout, done, ferr, perr, dout_p, done_p, ferr_p, perr_p});
    end
  endtask

  task automatic test_basic;
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs0.size() != exp0.size()) begin
      errors++; $display("FAIL basic_count: got %0d frames required %0d", obs0.size(), exp0.size());
    end
    while (obs0.size() > 0 && exp0.size() > 0) begin
      got = obs0.pop_front(); want = exp0.pop_front(); last0 = want[9:2]; checks++;
      if (got !== want) begin errors++; $display("FAIL basic_frame: got %h required %h", got, want); end
    end
    obs0.delete(); exp0.delete();
    repeat (300) @(negedge clk);
    checks++;
    if (dout !== last0) begin errors++; $display("FAIL basic_hold: got %h required %h", dout, last0); end
  endtask

  task automatic test_glitch;
    rx = 1'b0;
    repeat (4 * 16) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLK) @(negedge clk);
    checks++;
    if (obs0.size() != 0) begin
      errors++; $display("FAIL glitch_done: got %0d frames required 0", obs0.size());
    end
    checks++;
    if (dout !== last0) begin errors++; $display("FAIL glitch_dout: got %h required %h", dout, last0); end
    obs0.delete();
  endtask

  task automatic test_frame_err;
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (11 * BIT_CLK) @(negedge clk);
    checks++;
    if (obs0.size() != exp0.size()) begin
      errors++; $display("FAIL ferr_count: got %0d frames required %0d", obs0.size(), exp0.size());
    end
    while (obs0.size() > 0 && exp0.size() > 0) begin
      got = obs0.pop_front(); want = exp0.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL ferr_frame: got %h required %h", got, want); end
    end
    obs0.delete(); exp0.delete();
    rx = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    send_frame(0, 8'h96, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs0.size() != exp0.size()) begin
      errors++; $display("FAIL ferr_recover_count: got %0d frames required %0d", obs0.size(), exp0.size());
    end
    while (obs0.size() > 0 && exp0.size() > 0) begin
      got = obs0.pop_front(); want = exp0.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL ferr_recover_frame: got %h required %h", got, want); end
    end
    obs0.delete(); exp0.delete();
  endtask

  task automatic test_parity;
    logic [7:0] d;
    send_frame(1, 8'h01, 1'b0, 1'b1, 1'b0);
    send_frame(1, 8'h01, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(1, d, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
    checks++;
    if (obs1.size() != exp1.size()) begin
      errors++; $display("FAIL parity_count: got %0d frames required %0d", obs1.size(), exp1.size());
    end
    while (obs1.size() > 0 && exp1.size() > 0) begin
      got = obs1.pop_front(); want = exp1.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL parity_frame: got %h required %h", got, want); end
    end
    obs1.delete(); exp1.delete();
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    d = 8'h77;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, d[i]);
    rx = d[3];
    repeat (BIT_CLK / 2) @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    checks++;
    if ({dout, done, ferr, perr} !== 11'd0) begin
      errors++; $display("FAIL midreset_outputs: got %h required 000", {dout, done, ferr, perr});
    end
    checks++;
    if (obs0.size() != 0) begin
      errors++; $display("FAIL midreset_done: got %0d frames required 0", obs0.size());
    end
    obs0.delete();
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs0.size() != exp0.size()) begin
      errors++; $display("FAIL midreset_count: got %0d frames required %0d", obs0.size(), exp0.size());
    end
    while (obs0.size() > 0 && exp0.size() > 0) begin
      got = obs0.pop_front(); want = exp0.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL midreset_frame: got %h required %h", got, want); end
    end
    obs0.delete(); exp0.delete();
  endtask

  task automatic test_loopback;
    send_frame(0, 8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b0);
    send_frame(0, 8'h81, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs0.size() != exp0.size()) begin
      errors++; $display("FAIL loopback_count: got %0d frames required %0d", obs0.size(), exp0.size());
    end
    while (obs0.size() > 0 && exp0.size() > 0) begin
      got = obs0.pop_front(); want = exp0.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL loopback_frame: got %h required %h", got, want); end
    end
    obs0.delete(); exp0.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(0, d, 1'b0, 1'b1, 1'b1);
    end
    repeat (BIT_CLK) @(negedge clk);
    checks++;
    if (obs0.size() != exp0.size()) begin
      errors++; $display("FAIL b2b_count: got %0d frames required %0d", obs0.size(), exp0.size());
    end
    while (obs0.size() > 0 && exp0.size() > 0) begin
      got = obs0.pop_front(); want = exp0.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL b2b_frame: got %h required %h", got, want); end
    end
    obs0.delete(); exp0.delete();
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    rx_p = 1'b1;
    last0 = 8'd0;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_parity();
    test_reset_midframe();
    test_loopback();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
